volt_seg_dynamic: RTL and testbench

Downstream display stage for the voltmeter datapath. It samples the 16-bit magnitude `volt` (millivolts) and the `sign` flag produced by the ADC averaging/scaling stage. A sequential shift-add-3 FSM converts the sample to five BCD digits, and a six-digit common-anode 7-segment display is time-multiplexed as `±DD.DDD` V. All outputs are registered, so `sel` and `seg` change on the same edge and cannot ghost.

---
 rtl/volt_seg_dynamic.sv | 270 +++++++++++++++++++++++++++
 tb/tb_volt_seg_dynamic.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/volt_seg_dynamic.sv
// volt_seg_dynamic
// Display stage for the voltmeter datapath. Each sample of the unsigned mV
// magnitude and its sign is converted to five BCD digits by a sequential
// shift-add-3 engine. The result drives a six-digit common-anode 7-segment
// display, time-multiplexed as +/-DD.DDD V.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - blank the tens-of-volts digit (d4) when it is 0.
//
// sel and seg are both registered and update on the same tick edge, so a
// digit never shows another digit's segments.
module volt_seg_dynamic #(
    parameter int CNT_MAX = 49_999          // digit dwell minus one, in sys_clk cycles
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] volt,
    input  logic        sign,
    input  logic        disp_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int              CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX);

    localparam logic [1:0]      ST_IDLE  = 2'd0;
    localparam logic [1:0]      ST_SHIFT = 2'd1;
    localparam logic [1:0]      ST_LOAD  = 2'd2;

    localparam logic [7:0]      SEG_BLANK = 8'hFF;
    localparam logic [7:0]      SEG_MINUS = 8'hBF;
    localparam logic [7:0]      DP_MASK   = 8'h7F;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    // Active-low segment pattern for one BCD digit; illegal codes go blank.
    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Double-dabble correction of one nibble: add 3 when it is 5 or more,
    // so the following left shift carries correctly into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Apply the add-3 correction to all five decades of the accumulator.
    function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
        return {add3(bcd[19:16]), add3(bcd[15:12]), add3(bcd[11:8]),
                add3(bcd[7:4]),   add3(bcd[3:0])};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt_ms;
    logic [2:0]    r_idx;
    logic [1:0]    r_state;
    logic [15:0]   r_bin;
    logic [19:0]   r_bcd;
    logic [4:0]    r_bit_cnt;
    logic          r_sign_s;
    logic [19:0]   r_disp_bcd;
    logic          r_disp_sign;
    logic [5:0]    r_sel;
    logic [7:0]    r_seg;

    logic          w_tick;
    logic [2:0]    w_idx_nxt;
    logic          w_trig;
    logic [19:0]   w_bcd_adj;
    logic [3:0]    w_digit;
    logic [7:0]    w_code;
    logic [5:0]    w_sel_nxt;
    logic [7:0]    w_seg_nxt;

    assign w_tick    = (r_cnt_ms == CNT_LAST);
    assign w_idx_nxt = (r_idx == 3'd5) ? 3'd0 : (r_idx + 3'd1);
    // A new sample is taken once per refresh, on the tick that selects d0.
    assign w_trig    = w_tick && (r_idx == 3'd5);
    assign w_bcd_adj = bcd_adjust(r_bcd);

    assign sel = r_sel;
    assign seg = r_seg;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    // Dwell counter: counts 0..CNT_MAX and wraps, one tick per digit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_ms <= '0;
        end else if (w_tick) begin
            r_cnt_ms <= '0;
        end else begin
            r_cnt_ms <= r_cnt_ms + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Digit index: starts at 5 so that the first tick lands on d0.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idx <= 3'd5;
        end else if (w_tick) begin
            r_idx <= w_idx_nxt;
        end else begin
            r_idx <= r_idx;
        end
    end

    // ------------------------------------------------------------------
    // Binary to BCD conversion
    // ------------------------------------------------------------------
    // Shift-add-3 FSM; the display copy is only written in LOAD so a scan
    // never mixes digits from two different samples.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_bin       <= 16'd0;
            r_bcd       <= 20'd0;
            r_bit_cnt   <= 5'd0;
            r_sign_s    <= 1'b0;
            r_disp_bcd  <= 20'd0;
            r_disp_sign <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A trigger outside IDLE is dropped by construction.
                    if (w_trig) begin
                        r_bin     <= volt;
                        r_sign_s  <= sign;
                        r_bcd     <= 20'd0;
                        r_bit_cnt <= 5'd0;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_bit_cnt      <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd15) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_LOAD: begin
                    r_disp_bcd  <= r_bcd;
                    r_disp_sign <= r_sign_s;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Segment / select generation
    // ------------------------------------------------------------------
    // Pick the nibble for the digit about to be selected.
    always_comb begin
        w_digit = 4'd0;
        case (w_idx_nxt)
            3'd0:    w_digit = r_disp_bcd[3:0];
            3'd1:    w_digit = r_disp_bcd[7:4];
            3'd2:    w_digit = r_disp_bcd[11:8];
            3'd3:    w_digit = r_disp_bcd[15:12];
            3'd4:    w_digit = r_disp_bcd[19:16];
            default: w_digit = 4'd0;
        endcase
    end

    assign w_code = seg_code(w_digit);

    // Next segment pattern: dp on d3, optional zero blanking on d4, sign on
    // d5, and everything blank while the display is disabled.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        if (!disp_en) begin
            w_seg_nxt = SEG_BLANK;
        end else begin
            case (w_idx_nxt)
                3'd0, 3'd1, 3'd2: begin
                    w_seg_nxt = w_code;
                end
                3'd3: begin
                    w_seg_nxt = w_code & DP_MASK;
                end
                3'd4: begin
`ifdef LEADING_ZERO_BLANK_EN
                    if (w_digit == 4'd0) begin
                        w_seg_nxt = SEG_BLANK;
                    end else begin
                        w_seg_nxt = w_code;
                    end
`else
                    w_seg_nxt = w_code;
`endif
                end
                3'd5: begin
                    if (r_disp_sign) begin
                        w_seg_nxt = SEG_MINUS;
                    end else begin
                        w_seg_nxt = SEG_BLANK;
                    end
                end
                default: begin
                    w_seg_nxt = SEG_BLANK;
                end
            endcase
        end
    end

    // One-hot select for the digit about to be shown.
    always_comb begin
        w_sel_nxt = 6'b000000;
        case (w_idx_nxt)
            3'd0:    w_sel_nxt = 6'b000001;
            3'd1:    w_sel_nxt = 6'b000010;
            3'd2:    w_sel_nxt = 6'b000100;
            3'd3:    w_sel_nxt = 6'b001000;
            3'd4:    w_sel_nxt = 6'b010000;
            3'd5:    w_sel_nxt = 6'b100000;
            default: w_sel_nxt = 6'b000000;
        endcase
    end

    // Output registers: sel and seg load together on every tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sel <= 6'b000000;
            r_seg <= SEG_BLANK;
        end else if (w_tick) begin
            r_sel <= w_sel_nxt;
            r_seg <= w_seg_nxt;
        end else begin
            r_sel <= r_sel;
            r_seg <= r_seg;
        end
    end

endmodule

// File: tb/tb_volt_seg_dynamic.sv
// Testbench for volt_seg_dynamic with a 10-cycle dwell. The stimulus pushes
// the expected {sel, seg} of every digit into a queue; a monitor pops and
// compares each time a new digit is presented.
module tb_volt_seg_dynamic;

    localparam int CNT_MAX = 9;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] volt      = 16'd0;
    logic        sign      = 1'b0;
    logic        disp_en   = 1'b1;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [13:0] exp_q[$];
    logic [5:0]  prev_sel = 6'd0;

    typedef logic [7:0] dig6_t [0:5];

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] D4Z = 8'hFF;
`else
    localparam logic [7:0] D4Z = 8'hC0;
`endif

    dig6_t z_d, v3300_d, v12345_d, v65535_d, v1000_d, v2000_d, blk_d, v4321n_d;

    volt_seg_dynamic #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .volt      (volt),
        .sign      (sign),
        .disp_en   (disp_en),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 sys_clk = ~sys_clk;

    // Bench cycle count: edge number since reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Monitor: every new nonzero sel is one presented digit.
    always @(negedge sys_clk) begin
        if (sys_rst_n && sel != 6'd0 && sel != prev_sel) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scan_unexpected: got sel=%b seg=%h, required no digit", sel, seg);
            end else begin
                if ({sel, seg} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL scan_digit (cyc %0d): got sel=%b seg=%h, required sel=%b seg=%h",
                             cyc, sel, seg, exp_q[0][13:8], exp_q[0][7:0]);
                end
                void'(exp_q.pop_front());
            end
        end
        prev_sel <= sel;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step_to(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    // One refresh: d0,d1 still show the previous sample (LOAD lands after
    // the second tick with this dwell), d2..d5 show the new one.
    task automatic push_frame(input dig6_t o, input dig6_t n);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({6'(32'd1 << i), (i < 2) ? o[i] : n[i]});
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        z_d      = '{8'hC0, 8'hC0, 8'hC0, 8'h40, D4Z,   8'hFF};
        v3300_d  = '{8'hC0, 8'hC0, 8'hB0, 8'h30, D4Z,   8'hFF};
        v12345_d = '{8'h92, 8'h99, 8'hB0, 8'h24, 8'hF9, 8'hBF};
        v65535_d = '{8'h92, 8'hB0, 8'h92, 8'h12, 8'h82, 8'hFF};
        v1000_d  = '{8'hC0, 8'hC0, 8'hC0, 8'h79, D4Z,   8'hFF};
        v2000_d  = '{8'hC0, 8'hC0, 8'hC0, 8'h24, D4Z,   8'hFF};
        blk_d    = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        v4321n_d = '{8'hF9, 8'hA4, 8'hB0, 8'h19, D4Z,   8'hBF};

        push_frame(z_d,      z_d);        // trigger at edge 10, volt=0
        push_frame(z_d,      v3300_d);    // edge 70
        push_frame(v3300_d,  v12345_d);   // edge 130
        push_frame(v12345_d, v65535_d);   // edge 190
        push_frame(v65535_d, v1000_d);    // edge 250, volt changes at 255
        push_frame(v1000_d,  v2000_d);    // edge 310
        push_frame(blk_d,    blk_d);      // edge 370, disp_en=0
        exp_q.push_back({6'b000001, 8'hC0}); // edge 430, d0 of 2000

        repeat (3) @(negedge sys_clk);
        check("in_reset", {18'd0, sel, seg}, 32'h0000_00FF);
        sys_rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            step_to(c);
            check("post_reset_idle", {18'd0, sel, seg}, 32'h0000_00FF);
        end

        step_to(60);  volt = 16'd3300;
        step_to(120); volt = 16'd12345; sign = 1'b1;
        step_to(180); volt = 16'd65535; sign = 1'b0;
        step_to(206);
        check("bcd_before_load", {12'd0, dut.r_disp_bcd}, 32'h0001_2345);
        step_to(207);
        check("bcd_full_scale", {12'd0, dut.r_disp_bcd}, 32'h0006_5535);
        step_to(240); volt = 16'd1000;
        step_to(255); volt = 16'd2000;
        step_to(365); disp_en = 1'b0;
        step_to(425); disp_en = 1'b1; volt = 16'd4321; sign = 1'b1;

        step_to(438);
        sys_rst_n = 1'b0;
        #1;
        check("mid_conv_reset_out", {18'd0, sel, seg}, 32'h0000_00FF);
        check("mid_conv_reset_bcd", {12'd0, dut.r_disp_bcd}, 32'h0000_0000);
        check("phase1_drained", exp_q.size(), 32'd0);

        push_frame(z_d,      v4321n_d);
        push_frame(v4321n_d, v4321n_d);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step_to(5);
        check("post_reset2_idle", {18'd0, sel, seg}, 32'h0000_00FF);
        step_to(125);
        check("phase2_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
